// File: rtl/ifetch_buffer.sv
// rtl/ifetch_buffer.sv - MIPS instruction fetch stage with prefetch FIFO and redirect handling
//
// Owns the fetch PC, issues one word request at a time to instruction memory
// (req/ack), queues returned words with their PC in a DEPTH-entry FIFO and
// presents the head to decode over valid/ready. A redirect flushes the queue
// and restarts fetch at the target, discarding any in-flight response.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous reset, active low
//   redirect     branch taken / jump this cycle (highest priority)
//   redirect_pc  new fetch target when redirect=1
//   imem_req     memory request (registered)
//   imem_addr    memory request address (registered, stable while imem_req=1)
//   imem_ack     memory response valid, completes the current request
//   imem_rdata   instruction word returned by memory
//   out_valid    FIFO head valid
//   out_ready    decode accepts head this cycle
//   out_instr    head instruction (0 when empty)
//   out_pc       head PC (0 when empty)
//   out_pc4      head PC+4, wrapping (0 when empty)

module ifetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DROP
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [31:0]       req_addr_q, req_addr_d;

    logic [31:0]       instr_q [DEPTH];
    logic [31:0]       instr_d [DEPTH];
    logic [31:0]       pc_q    [DEPTH];
    logic [31:0]       pc_d    [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              push;
    logic              pop;
    logic              flush;
    logic              room;
    logic [CNT_W-1:0]  count_nx;

    // Push/pop are derived from registered state and inputs only, so the
    // FSM can use the post-update occupancy without a combinational loop.
    // A redirect suppresses both: the head is not consumed and the returning
    // word belongs to the abandoned path.
    always_comb begin
        flush    = redirect;
        push     = (state_q == ST_REQ) && imem_ack && !redirect;
        pop      = (count_q != '0) && out_ready && !redirect;
        count_nx = count_q + CNT_W'(push) - CNT_W'(pop);
        room     = count_nx < FULL;
    end

    // Fetch control FSM. fetch_pc is only consulted in IDLE and DROP, where
    // it always holds the next address to be issued.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end else if (count_q < FULL) begin
                    state_d    = ST_REQ;
                    req_addr_d = fetch_pc_q;
                end
            end

            ST_REQ: begin
                if (!imem_ack) begin
                    if (redirect) begin
                        // Request still outstanding: wait for its ack in DROP
                        // and throw the data away.
                        state_d    = ST_DROP;
                        fetch_pc_d = redirect_pc;
                    end
                end else if (redirect) begin
                    // Current request completes now, so the target can be
                    // issued next cycle without a bubble.
                    req_addr_d = redirect_pc;
                    fetch_pc_d = redirect_pc + 32'd4;
                end else if (room) begin
                    req_addr_d = req_addr_q + 32'd4;
                    fetch_pc_d = req_addr_q + 32'd8;
                end else begin
                    state_d    = ST_IDLE;
                    fetch_pc_d = req_addr_q + 32'd4;
                end
            end

            ST_DROP: begin
                if (!imem_ack) begin
                    if (redirect) begin
                        fetch_pc_d = redirect_pc;
                    end
                end else begin
                    // The FIFO is empty here (flushed on entry, no pushes in
                    // DROP), so the next request can always be issued.
                    state_d = ST_REQ;
                    if (redirect) begin
                        req_addr_d = redirect_pc;
                        fetch_pc_d = redirect_pc + 32'd4;
                    end else begin
                        req_addr_d = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO storage and pointers. Pointers wrap naturally since DEPTH is a
    // power of two; count carries one extra bit to represent full.
    always_comb begin
        instr_d  = instr_q;
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                instr_d[wr_ptr_q] = imem_rdata;
                pc_d[wr_ptr_q]    = req_addr_q;
                wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
        end
    end

    // Head outputs are forced to zero when empty so stale entries never leak
    // to decode and the reset values are well defined.
    always_comb begin
        imem_req  = (state_q != ST_IDLE);
        imem_addr = req_addr_q;
        out_valid = (count_q != '0);
        out_instr = '0;
        out_pc    = '0;
        out_pc4   = '0;
        if (out_valid) begin
            out_instr = instr_q[rd_ptr_q];
            out_pc    = pc_q[rd_ptr_q];
            out_pc4   = pc_q[rd_ptr_q] + 32'd4;
        end
    end

endmodule

// File: tb/tb_ifetch_buffer.sv
// tb/tb_ifetch_buffer.sv - directed table and sequence checks for ifetch_buffer

module tb_ifetch_buffer;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;

    int errors = 0;
    int checks = 0;

    ifetch_buffer #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_pc4     (out_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hA5C3_5A3C;
    endfunction

    // Memory returns the word for whatever address is presented; the bench
    // decides when ack is asserted.
    assign imem_rdata = instr_of(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge, apply inputs, settle.
    task automatic step(input logic rd, input logic [31:0] rpc, input logic ack, input logic rdy);
        @(negedge clk);
        redirect    = rd;
        redirect_pc = rpc;
        imem_ack    = ack;
        out_ready   = rdy;
        #1;
    endtask

    // Leaves reset released just after a rising edge, so the next step() is
    // the cycle before the first rising edge out of reset.
    task automatic do_reset();
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_ack    = 1'b0;
        out_ready   = 1'b0;
        reset       = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".pc"}, out_pc, pc);
        chk({tag, ".pc4"}, out_pc4, pc + 32'd4);
        chk({tag, ".instr"}, out_instr, instr_of(pc));
    endtask

    typedef struct {
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl [13];

    initial begin
        // ack held high throughout; ready low until the buffer fills.
        tbl[0]  = '{1'b0, 1'b0, 32'd0,  1'b0, 32'd0};
        tbl[1]  = '{1'b0, 1'b1, 32'd0,  1'b0, 32'd0};
        tbl[2]  = '{1'b0, 1'b1, 32'd4,  1'b1, 32'd0};
        tbl[3]  = '{1'b0, 1'b1, 32'd8,  1'b1, 32'd0};
        tbl[4]  = '{1'b0, 1'b1, 32'd12, 1'b1, 32'd0};
        tbl[5]  = '{1'b0, 1'b0, 32'd12, 1'b1, 32'd0};
        tbl[6]  = '{1'b1, 1'b0, 32'd12, 1'b1, 32'd0};
        tbl[7]  = '{1'b1, 1'b0, 32'd12, 1'b1, 32'd4};
        tbl[8]  = '{1'b1, 1'b1, 32'd16, 1'b1, 32'd8};
        tbl[9]  = '{1'b1, 1'b1, 32'd20, 1'b1, 32'd12};
        tbl[10] = '{1'b1, 1'b1, 32'd24, 1'b1, 32'd16};
        tbl[11] = '{1'b1, 1'b1, 32'd28, 1'b1, 32'd20};
        tbl[12] = '{1'b1, 1'b1, 32'd32, 1'b1, 32'd24};

        // Reset values
        do_reset();
        reset = 1'b0;
        #3;
        chk("rst.req",   {31'd0, imem_req}, 32'd0);
        chk("rst.addr",  imem_addr, 32'd0);
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        chk("rst.instr", out_instr, 32'd0);
        chk("rst.pc",    out_pc, 32'd0);
        chk("rst.pc4",   out_pc4, 32'd0);

        // Fill to DEPTH with ready low, then drain and stream
        do_reset();
        for (int i = 0; i < 13; i++) begin
            step(1'b0, 32'd0, 1'b1, tbl[i].ready);
            chk($sformatf("tbl[%0d].req", i), {31'd0, imem_req}, {31'd0, tbl[i].req});
            chk($sformatf("tbl[%0d].addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("tbl[%0d].valid", i), {31'd0, out_valid}, {31'd0, tbl[i].valid});
            if (tbl[i].valid) begin
                chk($sformatf("tbl[%0d].pc", i), out_pc, tbl[i].pc);
                chk($sformatf("tbl[%0d].pc4", i), out_pc4, tbl[i].pc + 32'd4);
                chk($sformatf("tbl[%0d].instr", i), out_instr, instr_of(tbl[i].pc));
            end
        end

        // Redirect while REQ waits for a slow ack: stale word dropped
        do_reset();
        step(1'b0, 32'h0,   1'b0, 1'b1);
        step(1'b1, 32'h100, 1'b0, 1'b1);
        chk("drop.req_c1", {31'd0, imem_req}, 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("drop.addr_held", imem_addr, 32'h0);
        chk("drop.valid_c2", {31'd0, out_valid}, 32'd0);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("drop.addr_tgt", imem_addr, 32'h100);
        chk("drop.valid_c4", {31'd0, out_valid}, 32'd0);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk_head("drop.h0", 32'h100);
        chk("drop.addr_next", imem_addr, 32'h104);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("drop.valid_c7", {31'd0, out_valid}, 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk_head("drop.h1", 32'h104);

        // Redirect coinciding with ack and a pop
        do_reset();
        step(1'b0, 32'h0,  1'b0, 1'b1);
        step(1'b0, 32'h0,  1'b1, 1'b1);
        step(1'b1, 32'h40, 1'b1, 1'b1);
        chk_head("same.pre", 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("same.valid", {31'd0, out_valid}, 32'd0);
        chk("same.req", {31'd0, imem_req}, 32'd1);
        chk("same.addr", imem_addr, 32'h40);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk_head("same.h0", 32'h40);

        // Two back-to-back redirects while in DROP
        do_reset();
        step(1'b0, 32'h0,   1'b0, 1'b1);
        step(1'b1, 32'h80,  1'b0, 1'b1);
        step(1'b1, 32'h200, 1'b0, 1'b1);
        step(1'b1, 32'h300, 1'b0, 1'b1);
        step(1'b0, 32'h0,   1'b1, 1'b1);
        chk("dbl.addr_old", imem_addr, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("dbl.addr", imem_addr, 32'h300);
        chk("dbl.valid", {31'd0, out_valid}, 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk_head("dbl.h0", 32'h300);
        chk("dbl.addr_next", imem_addr, 32'h304);

        // Address wrap-around
        do_reset();
        step(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("wrap.req_idle", {31'd0, imem_req}, 32'd0);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("wrap.addr0", imem_addr, 32'hFFFF_FFF8);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk_head("wrap.h0", 32'hFFFF_FFF8);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk_head("wrap.h1", 32'hFFFF_FFFC);
        chk("wrap.pc4_zero", out_pc4, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk_head("wrap.h2", 32'h0000_0000);

        // Asynchronous reset mid-transfer
        do_reset();
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("arst.pre_valid", {31'd0, out_valid}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst.req", {31'd0, imem_req}, 32'd0);
        chk("arst.valid", {31'd0, out_valid}, 32'd0);
        chk("arst.addr", imem_addr, 32'h0);
        @(posedge clk);
        #2 reset = 1'b1;
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("arst.req_c0", {31'd0, imem_req}, 32'd0);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("arst.req_c1", {31'd0, imem_req}, 32'd1);
        chk("arst.addr_c1", imem_addr, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk_head("arst.h0", 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifetch_buffer.md
# ifetch_buffer

Instruction fetch stage with a prefetch buffer, sitting directly upstream of decode/register-file read in the MIPS datapath. It owns the fetch PC and issues word requests to instruction memory over a req/ack handshake. It queues returned instructions with their PC and PC+4 in a DEPTH-entry FIFO and presents them to decode over a valid/ready handshake. A branch/jump redirect flushes the queue and restarts fetch at the target, safely discarding any in-flight response.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- redirect  in  1  branch taken / jump this cycle; highest priority.
- redirect_pc  in  32  new fetch target, valid when redirect=1.
- imem_req  out  1  instruction memory request, registered.
- imem_addr  out  32  request address, registered; stable while imem_req=1.
- imem_ack  in  1  imem_rdata valid; completes the current request.
- imem_rdata  in  32  instruction word.
- out_valid  out  1  FIFO head valid (count≠0).
- out_ready  in  1  decode accepts head this cycle.
- out_instr  out  32  head instruction.
- out_pc  out  32  head PC.
- out_pc4  out  32  head PC+4 (modulo 2^32).

## Operation
- State: fetch_pc (next address to request), req_addr (drives imem_addr), FIFO of {instr, pc} with count 0..DEPTH, FSM {IDLE, REQ, DROP}. imem_req = (state≠IDLE).
- At most one outstanding request. A request is complete in the cycle imem_ack=1 while imem_req=1. Ack may arrive in the same cycle req is first high (zero-wait). imem_ack while IDLE is ignored.
- Pop: out_valid & out_ready & !redirect. Push: ack in REQ & !redirect, writing {imem_rdata, req_addr}. Push and pop in the same cycle leave count unchanged.
- count_next = count + push − pop. Room = count_next < DEPTH.
- IDLE:
  - redirect → fetch_pc←redirect_pc, FIFO flushed (count←0), stay IDLE.
  - else if count < DEPTH → REQ, req_addr←fetch_pc.
- REQ, no ack:
  - redirect → DROP, fetch_pc←redirect_pc, flush.
  - else hold.
- REQ, ack:
  - redirect → data discarded, flush, REQ with req_addr←redirect_pc, fetch_pc←redirect_pc+4.
  - else push; fetch_pc←req_addr+4. If room → stay REQ with req_addr←req_addr+4, fetch_pc←req_addr+8. Else → IDLE.
- DROP, no ack: redirect → fetch_pc←redirect_pc, flush; stay DROP.
- DROP, ack:
  - Response discarded.
  - redirect → REQ with req_addr←redirect_pc.
  - else → REQ with req_addr←fetch_pc.
  - fetch_pc advances by 4 past the issued address.
- PC arithmetic is 32-bit wrapping: 32'hFFFF_FFFC+4 = 0. Low two address bits are passed through unchanged; no alignment check.
- Overflow is impossible by construction: a request is issued only when count < DEPTH, and only an ack increases count.

## Timing
- Reset values (asynchronous on reset=0):
  - state=IDLE, fetch_pc=RESET_PC, req_addr=RESET_PC, count=0.
  - imem_req=0, imem_addr=RESET_PC.
  - out_valid=0; out_instr, out_pc, out_pc4 = 0.
- imem_req first rises on the first rising edge after reset deasserts.
- With zero-wait memory, the first instruction appears on out_valid one cycle after its ack edge.
- Sustained throughput is 1 instruction/cycle when ack is always 1 and out_ready is always 1.
- Redirect flushes combinationally for pop purposes: the head is not consumed in a redirect cycle.
  - out_valid=0 the cycle after a redirect.
  - The first target instruction appears ≥2 cycles after the redirect edge: one cycle to issue in IDLE, plus memory latency.
- Reset mid-request drops the request (imem_req=0 immediately). The memory must tolerate the abandoned request.

## Test plan
- Reset, imem_ack tied 1, out_ready=1:
  - imem_addr = 0, 4, 8, … on consecutive cycles.
  - out_pc = 0, 4, 8 with out_instr matching memory.
  - out_pc4 = out_pc+4; one instruction per cycle.
- out_ready=0, ack=1:
  - Exactly DEPTH=4 entries (pc 0..12) are fetched, then imem_req=0.
  - Raising ready drains 0, 4, 8, 12 in order and fetching resumes at 16.
- Redirect to 32'h100 in REQ with no ack (3-cycle ack latency):
  - FSM enters DROP; the stale word at the old address is never output.
  - The next request address is 32'h100; out_pc sequence resumes 0x100, 0x104.
- Redirect in the same cycle as an ack and a pop:
  - No push, no pop, count=0.
  - The next imem_addr equals redirect_pc with no extra bubble.
- Two redirects (0x200, then 0x300) on consecutive cycles while in DROP:
  - Fetch resumes at 0x300 only.
- Wrap-around: redirect to 32'hFFFF_FFF8:
  - out_pc = FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - out_pc4 of 32'hFFFF_FFFC is 0.
- Assert reset low mid-transfer:
  - imem_req=0 and out_valid=0 asynchronously.
  - Fetch restarts at RESET_PC.
